// File: rtl/dmem_arb_pkg.sv
// Shared ownership type and default fairness limits for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    S_CPU  = 1'b0,
    S_HOST = 1'b1
  } owner_t;

  localparam int unsigned DefMaxBurst   = 16;
  localparam int unsigned DefCpuQuantum = 4;

endpackage

// File: rtl/sat_counter.sv
// Clear/increment/hold counter over 0..MAX-1 that saturates at MAX-1 and
// flags the terminal count.
module sat_counter #(
  parameter int unsigned MAX = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam int unsigned CW = (MAX > 1) ? $clog2(MAX) : 1;
  localparam logic [CW-1:0] Last = CW'(MAX - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != Last)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == Last);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the single-cycle core and a host requester
// using a registered owner with a host burst limit and a CPU quantum.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_BURST   = DefMaxBurst,
  parameter int unsigned CPU_QUANTUM = DefCpuQuantum
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  owner_t owner_q, owner_d;
  logic   beatClr, beatInc, beatTc;
  logic   quantClr, quantInc, quantTc;
  logic   memWe, hostGnt, stall;

  sat_counter #(.MAX(MAX_BURST)) u_beat_cnt (
    .clk_i (clk),
    .rst_ni(reset),
    .clr_i (beatClr),
    .inc_i (beatInc),
    .tc_o  (beatTc)
  );

  sat_counter #(.MAX(CPU_QUANTUM)) u_quant_cnt (
    .clk_i (clk),
    .rst_ni(reset),
    .clr_i (quantClr),
    .inc_i (quantInc),
    .tc_o  (quantTc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q <= S_CPU;
    end else begin
      owner_q <= owner_d;
    end
  end

  always_comb begin
    owner_d   = owner_q;
    beatClr   = 1'b0;
    beatInc   = 1'b0;
    quantClr  = 1'b0;
    quantInc  = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    memWe     = cpu_req & cpu_we;
    hostGnt   = 1'b0;
    stall     = 1'b0;
    unique case (owner_q)
      S_CPU: begin
        beatClr = 1'b1;
        if (host_req && (!cpu_req || quantTc)) begin
          owner_d  = S_HOST;
          quantClr = 1'b1;
        end else if (!host_req) begin
          quantClr = 1'b1;
        end else begin
          quantInc = 1'b1;
        end
      end
      S_HOST: begin
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
        memWe     = host_req & host_we;
        hostGnt   = host_req;
        stall     = cpu_req;
        quantClr  = 1'b1;
        // Burst beats only count against the limit while the core is waiting.
        if (!host_req || (cpu_req && beatTc)) begin
          owner_d = S_CPU;
          beatClr = 1'b1;
        end else if (cpu_req) begin
          beatInc = 1'b1;
        end
      end
      default: owner_d = S_CPU;
    endcase
  end

  // Reset kills any in-flight write or grant without waiting for a clock edge.
  assign mem_we     = memWe & reset;
  assign host_gnt   = hostGnt & reset;
  assign cpu_stall  = stall & reset;
  assign cpu_rdata  = mem_rdata;
  assign host_rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: per-cycle grant/stall expectations and
// host beat records are queued with the stimulus and popped as the DUT serves them.
module tb_dmem_arbiter;

  typedef struct packed {
    logic gnt;
    logic stall;
  } cyc_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        host_req, host_we;
  logic [31:0] host_addr, host_wdata, host_rdata;
  logic        host_gnt;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        clearMem;
  logic [31:0] memArr [0:1023];

  int testsRun    = 0;
  int testsFailed = 0;

  cyc_t        cycQ[$];
  beat_t       beatQ[$];
  logic [31:0] rdQ[$];

  dmem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_BURST(16), .CPU_QUANTUM(4)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_gnt(host_gnt),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on the rising edge.
  assign mem_rdata = memArr[mem_addr[11:2]];
  always @(posedge clk) begin
    if (clearMem) begin
      for (int i = 0; i < 1024; i++) memArr[i] <= 32'h0;
    end else if (mem_we) begin
      memArr[mem_addr[11:2]] <= mem_wdata;
    end
  end

  function automatic logic [31:0] patt(input logic [31:0] a);
    return 32'hA500_0000 | a;
  endfunction

  task automatic driveIdle();
    cpu_req = 0; cpu_we = 0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    host_req = 0; host_we = 0; host_addr = 32'h0; host_wdata = 32'h0;
  endtask

  task automatic pushCyc(input int n, input logic g, input logic s);
    for (int i = 0; i < n; i++) cycQ.push_back('{gnt: g, stall: s});
  endtask

  // Host streams nBeats writes while the core holds cReq; then tail idle-host cycles.
  task automatic runStream(input string tag, input int nBeats, input logic cReq,
                           input logic [31:0] base, input int tail);
    int k = 0;
    int cyc = 0;
    cyc_t e;
    beat_t b;
    for (int i = 0; i < nBeats; i++)
      beatQ.push_back('{addr: base + 32'(4 * i), data: patt(base + 32'(4 * i))});
    while (k < nBeats && cyc < 200) begin
      @(negedge clk);
      cpu_req = cReq; cpu_we = 0; cpu_addr = 32'h200;
      host_req = 1; host_we = 1; host_addr = base + 32'(4 * k); host_wdata = patt(host_addr);
      #2;
      testsRun++;
      if (cycQ.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL %s cycle %0d: got gnt=%b with no expectation left", tag, cyc, host_gnt);
      end else begin
        e = cycQ.pop_front();
        if (host_gnt !== e.gnt || cpu_stall !== e.stall || mem_we !== e.gnt) begin
          testsFailed++;
          $display("[TB] FAIL %s cycle %0d: got gnt=%b stall=%b we=%b expected gnt=%b stall=%b we=%b",
                   tag, cyc, host_gnt, cpu_stall, mem_we, e.gnt, e.stall, e.gnt);
        end
      end
      if (host_gnt === 1'b1) begin
        testsRun++;
        if (beatQ.size() == 0) begin
          testsFailed++;
          $display("[TB] FAIL %s beat: unexpected extra grant", tag);
        end else begin
          b = beatQ.pop_front();
          if (mem_addr !== b.addr || mem_wdata !== b.data) begin
            testsFailed++;
            $display("[TB] FAIL %s beat %0d: got addr=%h data=%h expected addr=%h data=%h",
                     tag, k, mem_addr, mem_wdata, b.addr, b.data);
          end
        end
        k++;
      end
      cyc++;
    end
    if (k < nBeats) begin
      testsRun++; testsFailed++;
      $display("[TB] FAIL %s timeout: got %0d beats expected %0d", tag, k, nBeats);
    end
    for (int t = 0; t < tail; t++) begin
      @(negedge clk);
      host_req = 0; host_we = 0; cpu_req = cReq; cpu_we = 0;
      #2;
      testsRun++;
      if (cycQ.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL %s tail %0d: got gnt=%b with no expectation left", tag, t, host_gnt);
      end else begin
        e = cycQ.pop_front();
        if (host_gnt !== e.gnt || cpu_stall !== e.stall || mem_we !== 1'b0) begin
          testsFailed++;
          $display("[TB] FAIL %s tail %0d: got gnt=%b stall=%b we=%b expected gnt=%b stall=%b we=0",
                   tag, t, host_gnt, cpu_stall, mem_we, e.gnt, e.stall);
        end
      end
    end
    cycQ.delete();
    beatQ.delete();
    @(negedge clk);
    driveIdle();
  endtask

  // Core reads each address; the expected word is queued when the read is issued.
  task automatic readBack(input string tag, input logic [31:0] addr, input logic [31:0] expData);
    logic [31:0] x;
    @(negedge clk);
    driveIdle();
    cpu_req = 1; cpu_addr = addr;
    rdQ.push_back(expData);
    #2;
    x = rdQ.pop_front();
    testsRun++;
    if (cpu_rdata !== x || host_rdata !== x || cpu_stall !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL %s read %h: got cpu=%h host=%h stall=%b expected %h stall=0",
               tag, addr, cpu_rdata, host_rdata, cpu_stall, x);
    end
  endtask

  task automatic test_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h40; cpu_wdata = 32'h1234_5678;
    host_req = 1; host_we = 1; host_addr = 32'h44; host_wdata = 32'h8765_4321;
    repeat (3) @(negedge clk);
    #2;
    testsRun++;
    if (host_gnt !== 1'b0 || mem_we !== 1'b0 || cpu_stall !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset outputs: got gnt=%b we=%b stall=%b expected 0 0 0",
               host_gnt, mem_we, cpu_stall);
    end
    testsRun++;
    if (cpu_rdata !== 32'h0 || host_rdata !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset rdata: got cpu=%h host=%h expected 0", cpu_rdata, host_rdata);
    end
    @(negedge clk);
    driveIdle();
    clearMem = 0;
    reset = 1;
    #2;
    testsRun++;
    if (host_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL post-reset idle: got gnt=%b stall=%b expected 0 0", host_gnt, cpu_stall);
    end
  endtask

  task automatic test_cpu_only();
    logic [31:0] x;
    @(negedge clk);
    driveIdle();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h40; cpu_wdata = 32'hDEAD_BEEF;
    rdQ.push_back(32'hDEAD_BEEF);
    #2;
    testsRun++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'hDEAD_BEEF || cpu_stall !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL cpu store: got we=%b addr=%h data=%h stall=%b expected 1 00000040 deadbeef 0",
               mem_we, mem_addr, mem_wdata, cpu_stall);
    end
    @(negedge clk);
    cpu_we = 0;
    #2;
    x = rdQ.pop_front();
    testsRun++;
    if (cpu_rdata !== x || mem_we !== 1'b0 || cpu_stall !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL cpu load: got rdata=%h we=%b stall=%b expected %h 0 0",
               cpu_rdata, mem_we, cpu_stall, x);
    end
    @(negedge clk);
    driveIdle();
  endtask

  task automatic test_host_only();
    pushCyc(1, 0, 0); pushCyc(8, 1, 0); pushCyc(2, 0, 0);
    runStream("host_only", 8, 1'b0, 32'h100, 2);
    for (int i = 0; i < 8; i++)
      readBack("host_only", 32'h100 + 32'(4 * i), patt(32'h100 + 32'(4 * i)));
  endtask

  task automatic test_contention();
    pushCyc(4, 0, 0); pushCyc(16, 1, 1);
    pushCyc(4, 0, 0); pushCyc(16, 1, 1);
    pushCyc(4, 0, 0); pushCyc(8, 1, 1);
    pushCyc(1, 0, 1); pushCyc(1, 0, 0);
    runStream("contention", 40, 1'b1, 32'h400, 2);
    readBack("contention", 32'h49C, patt(32'h49C));
  endtask

  task automatic test_simultaneous();
    cyc_t e;
    logic [31:0] expAddr;
    pushCyc(4, 0, 0); pushCyc(1, 1, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'h300 + 32'(4 * c); cpu_wdata = patt(cpu_addr);
      host_req = 1; host_we = 1; host_addr = 32'h380; host_wdata = 32'h0BAD_F00D;
      #2;
      e = cycQ.pop_front();
      expAddr = e.gnt ? 32'h380 : cpu_addr;
      testsRun++;
      if (host_gnt !== e.gnt || cpu_stall !== e.stall || mem_we !== 1'b1 || mem_addr !== expAddr) begin
        testsFailed++;
        $display("[TB] FAIL simultaneous cycle %0d: got gnt=%b stall=%b we=%b addr=%h expected %b %b 1 %h",
                 c, host_gnt, cpu_stall, mem_we, mem_addr, e.gnt, e.stall, expAddr);
      end
    end
    @(negedge clk);
    driveIdle();
    #2;
    testsRun++;
    if (host_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL simultaneous release: got gnt=%b stall=%b expected 0 0", host_gnt, cpu_stall);
    end
    for (int c = 0; c < 4; c++)
      readBack("simultaneous", 32'h300 + 32'(4 * c), patt(32'h300 + 32'(4 * c)));
    readBack("simultaneous", 32'h380, 32'h0BAD_F00D);
    readBack("simultaneous stalled store", 32'h310, 32'h0);
  endtask

  task automatic test_reset_mid_burst();
    cyc_t e;
    int k = 0;
    int cyc = 0;
    bit hit = 0;
    pushCyc(4, 0, 0); pushCyc(6, 1, 1);
    while (!hit && cyc < 40) begin
      @(negedge clk);
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h200;
      host_req = 1; host_we = 1; host_addr = 32'h600 + 32'(4 * k); host_wdata = patt(host_addr);
      #2;
      testsRun++;
      if (cycQ.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL mid_burst cycle %0d: got gnt=%b with no expectation left", cyc, host_gnt);
      end else begin
        e = cycQ.pop_front();
        if (host_gnt !== e.gnt || cpu_stall !== e.stall) begin
          testsFailed++;
          $display("[TB] FAIL mid_burst cycle %0d: got gnt=%b stall=%b expected %b %b",
                   cyc, host_gnt, cpu_stall, e.gnt, e.stall);
        end
      end
      if (host_gnt === 1'b1) begin
        if (k == 5) hit = 1;
        else k++;
      end
      cyc++;
    end
    cycQ.delete();
    if (!hit) begin
      testsRun++; testsFailed++;
      $display("[TB] FAIL mid_burst timeout: got %0d beats expected 6", k);
    end
    #1 reset = 0;
    #1;
    testsRun++;
    if (host_gnt !== 1'b0 || mem_we !== 1'b0 || cpu_stall !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL mid_burst async reset: got gnt=%b we=%b stall=%b expected 0 0 0",
               host_gnt, mem_we, cpu_stall);
    end
    @(posedge clk);
    @(negedge clk);
    driveIdle();
    reset = 1;
    readBack("mid_burst last beat", 32'h610, patt(32'h610));
    readBack("mid_burst interrupted", 32'h614, 32'h0);
  endtask

  task automatic test_limit_drop();
    pushCyc(4, 0, 0); pushCyc(15, 1, 1);
    pushCyc(1, 0, 1); pushCyc(3, 0, 0);
    runStream("limit_drop", 15, 1'b1, 32'h800, 4);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", testsRun);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 0;
    clearMem = 1;
    driveIdle();
    test_reset();
    test_cpu_only();
    test_host_only();
    test_contention();
    test_simultaneous();
    test_reset_mid_burst();
    test_simultaneous();
    test_limit_drop();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
